video_pixel_packer: RTL and testbench
=====================================

Name: video_pixel_packer

Overview:
Per-camera capture stage that sits directly upstream of the video-to-AXI write path, one instance per CMOS port. It runs entirely in that camera's pixel clock. It takes the sim/real CMOS stream (vsync/href/clken/24-bit RGB) and packs 4 pixels into each 128-bit AXI-width word. Words are buffered in a small FIFO and presented on a valid/ready interface, tagged with start-of-frame and end-of-line flags so the write master can restart frame addresses and stride lines.

Parameters:
DATA_WIDTH, 128, output word width; must equal 4*32.
PIX_WIDTH, 24, input pixel width (RGB888).
IMG_HDISP, 1920, expected pixels per line.
IMG_VDISP, 1080, expected lines per frame.
FIFO_DEPTH, 16, output buffer depth in words; power of two, at least 4.

Ports:
clk  in  1  camera pixel clock; sole clock of the block.
rst_n  in  1  asynchronous active-low reset.
cmos_vsync  in  1  frame sync; rising edge marks frame start.
cmos_href  in  1  line valid.
cmos_clken  in  1  pixel qualifier; a pixel is accepted when href&&clken.
cmos_data  in  24  pixel {R,G,B}.
out_valid  out  1  word available.
out_ready  in  1  consumer accepts the word when valid&&ready.
out_data  out  128  4 pixels; pixel k in bits [32k+23:32k], bits [32k+31:32k+24]=0.
out_sof  out  1  word is the first of a frame.
out_eol  out  1  word holds the last pixel of a line.
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
overflow  out  1  sticky: a word was dropped on a full FIFO; cleared at frame start.
line_err  out  1  sticky: a line ended with a pixel count other than IMG_HDISP, or a frame ended with a line count other than IMG_VDISP; cleared at frame start.

Behaviour:
- Reset: all outputs 0. Lane index, x/y counters, sof_pending and FIFO pointers are all 0. A partial word is discarded. Asynchronous reset mid-line resumes cleanly at the next vsync rise. Pixels arriving before the first vsync rise are ignored (armed=0).
- Frame start (vsync_d1=0, vsync=1):
  - armed=1, sof_pending=1, x=y=0, lane=0.
  - overflow and line_err are cleared.
  - line_err is set first if the previous frame's y!=IMG_VDISP and armed was already 1.
- Pixel accept (armed&&href&&clken): the pixel is written to lane[lane] of the pack register, and lane and x increment.
  - When lane==3, or x==IMG_HDISP-1, the word is pushed next cycle. That word carries sof=sof_pending and eol=(x==IMG_HDISP-1).
  - On push, sof_pending clears and lane wraps to 0.
  - Unused lanes of a partial word are zero.
- Line end (href_d1=1, href=0): if lane!=0 (short line), the partial word is pushed with eol=1.
  - line_err is set if x!=IMG_HDISP; y increments and x clears.
  - If x exceeds IMG_HDISP within a line, line_err is set. Extra pixels are still packed, with no eol on them.
- Simultaneous events, in priority order:
  1. A line-end flush completes before a same-cycle frame start.
  2. A pixel accepted in the same cycle as a frame start is pixel 0 of the new frame.
- FIFO: synchronous, first-word-fall-through, width 130 (data+sof+eol).
  - Push when full: the word is dropped and overflow is set. The packer never stalls, because the CMOS source cannot be back-pressured.
  - Simultaneous push and pop when full is a legal push (no drop).
- Latency: with the FIFO empty, the 4th pixel accepted at cycle N gives the FIFO write at N+1 and out_valid=1 at N+2.
- Handshake: out_data, out_sof and out_eol are stable while out_valid&&!out_ready. out_valid drops only after a pop empties the FIFO.
- Arithmetic: x is 12 bits and y is 11 bits, both saturating at their maximum.

Decomposition:
- Shared package video_pkg:
  - PIX_PER_WORD=4, PIX_LANE_W=32.
  - A typedef for the packed FIFO entry {sof, eol, data[127:0]}.
  - Default IMG_HDISP/IMG_VDISP.
- One sub-module: video_pack_fifo, the parameterised sync FWFT FIFO with level output. The packer FSM and counters stay in video_pixel_packer.

Test Plan:
- IMG_HDISP=8, IMG_VDISP=2, out_ready=1; pixels 0x000001..0x000010 → 4 words. Word0 data lanes 0x1,0x2,0x3,0x4 with sof=1. Word1 eol=1. Word3 eol=1, sof=0. line_err=0.
- IMG_HDISP=6: a line of 6 pixels → word0 full; word1 lanes 4,5 then zeros, with eol=1. A 5-pixel line → partial flush at href fall with eol=1 and line_err=1.
- out_ready=0 for 20 full words with FIFO_DEPTH=16 → fifo_level=16, overflow=1, and exactly 4 words dropped. The next vsync rise clears overflow. Draining yields the 16 oldest words in order.
- Back-pressure: toggle out_ready randomly → out_data is held stable while valid&&!ready, and the received sequence equals the sent sequence.
- Assert rst_n low mid-line after 2 pixels → outputs 0 immediately. Pixels before the next vsync rise produce no words. The first word after it has sof=1.
- Same-cycle href fall (lane=2) and vsync rise → the partial word is emitted with eol=1, sof=0. The next word has sof=1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the camera capture path: pixel lanes,
// the buffered word format and the lane packing helper.
package video_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int PIX_LANE_W = 32;
  localparam int PIX_W = 24;
  localparam int WORD_W = PIX_PER_WORD * PIX_LANE_W;
  localparam int DEF_HDISP = 1920;
  localparam int DEF_VDISP = 1080;

  typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] pix_t;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] data;
  } word_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input pix_t p
  );
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < PIX_PER_WORD; k++)
      w[k*PIX_LANE_W +: PIX_W] = p[k];
    return w;
  endfunction

endpackage

// File: rtl/video_pack_fifo.sv
// First-word-fall-through word buffer; a push into a full
// buffer is dropped unless a pop frees a slot that cycle.
module video_pack_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  word_t         din,
  output logic          drop,
  input  logic          ready,
  output logic          valid,
  output word_t         dout,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr;
  logic [AW-1:0]  rd;
  logic           full;
  logic           pop;
  logic           wr_en;

  assign full  = level == LW'(DEPTH);
  assign valid = level != '0;
  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = valid ? mem[rd] : '0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (wr_en)
        wr <= wr + AW'(1);
      if (pop)
        rd <= rd + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/video_pixel_packer.sv
// Per-camera capture: packs four RGB pixels per 128-bit word
// with frame/line tags and buffers words for the write master.
module video_pixel_packer
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int PIX_WIDTH = 24,
  parameter int IMG_HDISP = DEF_HDISP,
  parameter int IMG_VDISP = DEF_VDISP,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmos_vsync,
  input  logic                        cmos_href,
  input  logic                        cmos_clken,
  input  logic [PIX_WIDTH-1:0]        cmos_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        line_err
);

  localparam logic [11:0] HD = 12'(IMG_HDISP);
  localparam logic [11:0] HLAST = 12'(IMG_HDISP - 1);
  localparam logic [10:0] VD = 11'(IMG_VDISP);

  logic        vsync_d1, href_d1, armed, sof_pending;
  logic [11:0] x, x_n;
  logic [10:0] y, y_n;
  logic [1:0]  lane, lane_n;
  pix_t        pix, pix_n;
  word_t       stg, stg_n, dout;
  logic        push_q, push_n, sof_n, err_n, drop;
  logic        fs, le, acc;

  assign fs  = cmos_vsync && !vsync_d1;
  assign le  = armed && href_d1 && !cmos_href;
  assign acc = (armed || fs) && cmos_href && cmos_clken;

  // Flush of the old line first, then frame restart, then the pixel.
  always_comb begin
    pix_n  = pix;
    lane_n = lane;
    x_n    = x;
    y_n    = y;
    sof_n  = sof_pending;
    err_n  = line_err;
    stg_n  = stg;
    push_n = 1'b0;
    if (le) begin
      if (lane != 2'd0) begin
        push_n = 1'b1;
        stg_n  = '{sof: sof_n, eol: 1'b1, data: pack_word(pix)};
        sof_n  = 1'b0;
        lane_n = 2'd0;
        pix_n  = '0;
      end
      if (x != HD)
        err_n = 1'b1;
      y_n = (y == '1) ? y : y + 11'd1;
      x_n = '0;
    end
    if (fs) begin
      err_n  = armed && (y_n != VD);
      sof_n  = 1'b1;
      x_n    = '0;
      y_n    = '0;
      lane_n = 2'd0;
      pix_n  = '0;
    end
    if (acc) begin
      pix_n[lane_n] = cmos_data;
      if (x_n >= HD)
        err_n = 1'b1;
      if (lane_n == 2'd3 || x_n == HLAST) begin
        push_n = 1'b1;
        stg_n  = '{sof: sof_n, eol: x_n == HLAST,
                   data: pack_word(pix_n)};
        sof_n  = 1'b0;
        lane_n = 2'd0;
        pix_n  = '0;
      end else begin
        lane_n = lane_n + 2'd1;
      end
      x_n = (x_n == '1) ? x_n : x_n + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1    <= 1'b0;
      href_d1     <= 1'b0;
      armed       <= 1'b0;
      sof_pending <= 1'b0;
      x           <= '0;
      y           <= '0;
      lane        <= '0;
      pix         <= '0;
      stg         <= '0;
      push_q      <= 1'b0;
      overflow    <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      vsync_d1    <= cmos_vsync;
      href_d1     <= cmos_href;
      armed       <= armed || fs;
      sof_pending <= sof_n;
      x           <= x_n;
      y           <= y_n;
      lane        <= lane_n;
      pix         <= pix_n;
      stg         <= stg_n;
      push_q      <= push_n;
      overflow    <= fs ? 1'b0 : (overflow || drop);
      line_err    <= err_n;
    end
  end

  video_pack_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (stg),
    .drop  (drop),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (dout),
    .level (fifo_level)
  );

  assign out_data = dout.data;
  assign out_sof  = dout.sof;
  assign out_eol  = dout.eol;

endmodule

// File: tb/tb_video_pixel_packer.sv
// Directed checks of the pixel packer: packing, tagging,
// overflow, back-pressure, reset and frame/line collisions.
module tb_video_pixel_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0, href = 1'b0, clken = 1'b0;
  logic ready = 1'b0, rnd = 1'b0;
  logic [23:0] data = '0;

  logic va, sofa, eola, ova, lea;
  logic vb, sofb, eolb, ovb, leb;
  logic [127:0] da, db;
  logic [4:0] lva, lvb;

  logic [129:0] qa[$];
  logic [129:0] qb[$];
  logic [129:0] held = '0;
  logic hold = 1'b0;
  int total = 0;
  int bad = 0;
  int base, baseb;

  always #5 clk = ~clk;

  video_pixel_packer #(
    .IMG_HDISP(8), .IMG_VDISP(2), .FIFO_DEPTH(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .cmos_vsync(vs), .cmos_href(href),
    .cmos_clken(clken), .cmos_data(data),
    .out_valid(va), .out_ready(ready),
    .out_data(da), .out_sof(sofa), .out_eol(eola),
    .fifo_level(lva), .overflow(ova), .line_err(lea)
  );

  video_pixel_packer #(
    .IMG_HDISP(6), .IMG_VDISP(2), .FIFO_DEPTH(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmos_vsync(vs), .cmos_href(href),
    .cmos_clken(clken), .cmos_data(data),
    .out_valid(vb), .out_ready(ready),
    .out_data(db), .out_sof(sofb), .out_eol(eolb),
    .fifo_level(lvb), .overflow(ovb), .line_err(leb)
  );

  task automatic chk(input string tag,
                     input logic [129:0] got,
                     input logic [129:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [129:0] wexp(
    input bit s, input bit e,
    input logic [23:0] p0, input logic [23:0] p1,
    input logic [23:0] p2, input logic [23:0] p3);
    return {s, e, 8'h0, p3, 8'h0, p2, 8'h0, p1, 8'h0, p0};
  endfunction

  function automatic logic [129:0] geta(input int i);
    return (i < qa.size()) ? qa[i] : 'x;
  endfunction

  function automatic logic [129:0] getb(input int i);
    return (i < qb.size()) ? qb[i] : 'x;
  endfunction

  // Capture pops and check held data while stalled.
  always @(negedge clk) begin
    #1;
    if (rst_n && hold && va)
      chk("hold", {sofa, eola, da}, held);
    hold = rst_n && va && !ready;
    held = {sofa, eola, da};
    if (rst_n && va && ready)
      qa.push_back({sofa, eola, da});
    if (rst_n && vb && ready)
      qb.push_back({sofb, eolb, db});
  end

  task automatic drv(input logic v, input logic h,
                     input logic c, input logic [23:0] d);
    @(negedge clk);
    vs = v;
    href = h;
    clken = c;
    data = d;
    if (rnd)
      ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic frame();
    drv(1'b1, 1'b0, 1'b0, 24'h0);
    drv(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic line(input int n, input logic [23:0] p);
    for (int i = 0; i < n; i++)
      drv(1'b0, 1'b1, 1'b1, p + 24'(i));
    idle(2);
  endtask

  task automatic reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  // Checks n words of an 8-pixel-line stream starting at pixel p.
  task automatic words8(input int b, input int n,
                        input logic [23:0] p);
    for (int k = 0; k < n; k++)
      chk("word8", geta(b + k),
          wexp(k == 0, (k % 2) == 1,
               p + 24'(4*k), p + 24'(4*k+1),
               p + 24'(4*k+2), p + 24'(4*k+3)));
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_valid", 130'(va), 130'(0));
    chk("rst_level", 130'(lva), 130'(0));
    chk("rst_data", {sofa, eola, da}, 130'(0));
    chk("rst_flags", 130'({ova, lea, vb, ovb, leb}), 130'(0));
    chk("rst_level_b", 130'(lvb), 130'(0));
    reset();

    // latency: 4th pixel at N, valid at N+2
    ready = 1'b0;
    frame();
    for (int i = 1; i <= 4; i++)
      drv(1'b0, 1'b1, 1'b1, 24'(i));
    idle(1);
    #1;
    chk("lat_n1", 130'(va), 130'(0));
    idle(1);
    #1;
    chk("lat_n2", 130'(va), 130'(1));
    chk("lat_level", 130'(lva), 130'(1));
    reset();

    // basic packing, H=8 V=2
    ready = 1'b1;
    base = qa.size();
    frame();
    line(8, 24'h1);
    line(8, 24'h9);
    idle(4);
    #2;
    chk("t1_count", 130'(qa.size() - base), 130'(4));
    chk("t1_w0", geta(base),
        wexp(1, 0, 24'h1, 24'h2, 24'h3, 24'h4));
    chk("t1_w1", geta(base + 1),
        wexp(0, 1, 24'h5, 24'h6, 24'h7, 24'h8));
    chk("t1_w3", geta(base + 3),
        wexp(0, 1, 24'hd, 24'he, 24'hf, 24'h10));
    chk("t1_lerr", 130'(lea), 130'(0));
    frame();
    chk("t1_lerr_vs", 130'(lea), 130'(0));
    reset();

    // H=6: full line, then short line
    ready = 1'b1;
    baseb = qb.size();
    frame();
    line(6, 24'h1);
    chk("t2_lerr0", 130'(leb), 130'(0));
    line(5, 24'h11);
    idle(3);
    #2;
    chk("t2_count", 130'(qb.size() - baseb), 130'(4));
    chk("t2_w0", getb(baseb),
        wexp(1, 0, 24'h1, 24'h2, 24'h3, 24'h4));
    chk("t2_w1", getb(baseb + 1),
        wexp(0, 1, 24'h5, 24'h6, 24'h0, 24'h0));
    chk("t2_w2", getb(baseb + 2),
        wexp(0, 0, 24'h11, 24'h12, 24'h13, 24'h14));
    chk("t2_w3", getb(baseb + 3),
        wexp(0, 1, 24'h15, 24'h0, 24'h0, 24'h0));
    chk("t2_lerr1", 130'(leb), 130'(1));
    frame();
    chk("t2_lerr_clr", 130'(leb), 130'(0));
    reset();

    // overflow: 20 words into depth 16
    ready = 1'b0;
    frame();
    for (int l = 0; l < 10; l++)
      line(8, 24'(1 + 8*l));
    chk("t3_level", 130'(lva), 130'(16));
    chk("t3_ovf", 130'(ova), 130'(1));
    frame();
    chk("t3_ovf_clr", 130'(ova), 130'(0));
    chk("t3_lerr_v", 130'(lea), 130'(1));
    base = qa.size();
    ready = 1'b1;
    idle(20);
    #2;
    chk("t3_count", 130'(qa.size() - base), 130'(16));
    words8(base, 16, 24'h1);
    reset();

    // random back-pressure
    base = qa.size();
    frame();
    rnd = 1'b1;
    line(8, 24'h101);
    line(8, 24'h109);
    rnd = 1'b0;
    ready = 1'b1;
    idle(10);
    #2;
    chk("t4_count", 130'(qa.size() - base), 130'(4));
    words8(base, 4, 24'h101);
    reset();

    // async reset mid-line
    ready = 1'b0;
    frame();
    line(8, 24'h71);
    drv(1'b0, 1'b1, 1'b1, 24'h41);
    drv(1'b0, 1'b1, 1'b1, 24'h42);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 130'(va), 130'(0));
    chk("t5_level", 130'(lva), 130'(0));
    chk("t5_data", {sofa, eola, da}, 130'(0));
    drv(1'b0, 1'b1, 1'b1, 24'h43);
    drv(1'b0, 1'b1, 1'b1, 24'h44);
    rst_n = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 24'h45);
    drv(1'b0, 1'b1, 1'b1, 24'h46);
    idle(1);
    ready = 1'b1;
    base = qa.size();
    line(8, 24'h81);
    idle(4);
    #2;
    chk("t5_unarmed", 130'(qa.size() - base), 130'(0));
    frame();
    line(8, 24'h51);
    idle(4);
    #2;
    chk("t5_count", 130'(qa.size() - base), 130'(2));
    chk("t5_sof", geta(base),
        wexp(1, 0, 24'h51, 24'h52, 24'h53, 24'h54));
    reset();

    // href fall and vsync rise together
    ready = 1'b1;
    base = qa.size();
    frame();
    line(8, 24'h61);
    drv(1'b0, 1'b1, 1'b1, 24'h21);
    drv(1'b0, 1'b1, 1'b1, 24'h22);
    drv(1'b1, 1'b0, 1'b0, 24'h0);
    drv(1'b0, 1'b0, 1'b0, 24'h0);
    line(8, 24'h31);
    idle(4);
    #2;
    chk("t6_count", 130'(qa.size() - base), 130'(5));
    chk("t6_flush", geta(base + 2),
        wexp(0, 1, 24'h21, 24'h22, 24'h0, 24'h0));
    chk("t6_sof", geta(base + 3),
        wexp(1, 0, 24'h31, 24'h32, 24'h33, 24'h34));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
